// File: rtl/cascade_cache_dumper.sv
// cascade_cache_dumper: reads the cascade cache in address order and streams it out as packed 64-bit beats
module cascade_cache_dumper #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 32,
    parameter int NUM_WORDS  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WORD_SIZE-1:0]  rdata,
    output logic [63:0]           data,
    output logic                  data_ready,
    input  logic                  data_wanted
);
    localparam int WPB = 64 / WORD_SIZE;
    localparam int LW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [ADDR_WIDTH:0] NW        = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST      = (ADDR_WIDTH+1)'(NUM_WORDS - 1);
    localparam logic [LW-1:0]       LAST_LANE = LW'(WPB - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SEND, DONE} state_t;

    state_t              state, nxt;
    logic [ADDR_WIDTH:0] addr;
    logic [LW-1:0]       lane, cap_lane;
    logic                cap_valid;
    logic [63:0]         beat;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // next state and decoded outputs
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? FETCH : IDLE;
            FETCH:   nxt = (lane == LAST_LANE || addr == LAST) ? DRAIN : FETCH;
            DRAIN:   nxt = SEND;
            SEND:    nxt = data_wanted ? ((addr == NW) ? DONE : FETCH) : SEND;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        busy       = state != IDLE;
        done       = state == DONE;
        re         = state == FETCH;
        data_ready = state == SEND;
        raddr      = addr[ADDR_WIDTH-1:0];
        data       = beat;
    end

    // address/lane counters and beat assembly; read data lands one cycle after its read, in the lane of that read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            lane      <= '0;
            cap_lane  <= '0;
            cap_valid <= 1'b0;
            beat      <= '0;
        end else begin
            cap_valid <= state == FETCH;
            cap_lane  <= lane;
            if (state == IDLE && start) begin
                addr <= '0;
                lane <= '0;
                beat <= '0;
            end
            if (state == FETCH) begin
                addr <= addr + 1'b1;
                lane <= lane + 1'b1;
            end
            if (state == SEND && data_wanted && addr != NW) begin
                lane <= '0;
                beat <= '0;
            end
            if (cap_valid) beat[int'(cap_lane)*WORD_SIZE +: WORD_SIZE] <= rdata;
        end
    end
endmodule

// File: tb/tb_cascade_cache_dumper.sv
// tb_cascade_cache_dumper: cycle table for a 32-bit dump, scoreboarded streams for partial, stalled, reset and full-depth dumps
module tb_cascade_cache_dumper;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // instance a: 16-bit words, 5 words (partial last beat)
    logic        start_a = 0, busy_a, done_a, re_a, dr_a, want_a = 1;
    logic [3:0]  raddr_a;
    logic [15:0] rdata_a = '0;
    logic [63:0] data_a;
    logic [15:0] mem_a [16];
    cascade_cache_dumper #(.ADDR_WIDTH(4), .WORD_SIZE(16), .NUM_WORDS(5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .re(re_a),
        .raddr(raddr_a), .rdata(rdata_a), .data(data_a), .data_ready(dr_a), .data_wanted(want_a));
    always @(posedge clk) if (re_a) rdata_a <= mem_a[raddr_a];

    // instance b: 32-bit words, 4 words, full depth of a 2-bit address
    logic        start_b = 0, busy_b, done_b, re_b, dr_b, want_b = 1;
    logic [1:0]  raddr_b;
    logic [31:0] rdata_b = '0;
    logic [63:0] data_b;
    logic [31:0] mem_b [4];
    cascade_cache_dumper #(.ADDR_WIDTH(2), .WORD_SIZE(32), .NUM_WORDS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .re(re_b),
        .raddr(raddr_b), .rdata(rdata_b), .data(data_b), .data_ready(dr_b), .data_wanted(want_b));
    always @(posedge clk) if (re_b) rdata_b <= mem_b[raddr_b];

    // instance c: 64-bit words, 16 words, full depth of a 4-bit address
    logic        start_c = 0, busy_c, done_c, re_c, dr_c, want_c = 1;
    logic [3:0]  raddr_c;
    logic [63:0] rdata_c = '0;
    logic [63:0] data_c;
    logic [63:0] mem_c [16];
    cascade_cache_dumper #(.ADDR_WIDTH(4), .WORD_SIZE(64), .NUM_WORDS(16)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c), .re(re_c),
        .raddr(raddr_c), .rdata(rdata_c), .data(data_c), .data_ready(dr_c), .data_wanted(want_c));
    always @(posedge clk) if (re_c) rdata_c <= mem_c[raddr_c];

    // scoreboards: expected beats are queued at start, popped on every transfer
    logic [63:0] q_a [$];
    logic [63:0] q_c [$];
    int re_cnt_a = 0, beats_a = 0, done_cnt_a = 0;
    int re_cnt_c = 0, beats_c = 0, rexp_c = 0;
    logic busy_d_a = 0, busy_d_c = 0;
    logic [15:0] copy_a [5];

    always @(negedge clk) begin
        if (busy_a && !busy_d_a) begin
            re_cnt_a = 0;
            beats_a = 0;
        end
        busy_d_a = busy_a;
        if (re_a) re_cnt_a++;
        if (done_a) done_cnt_a++;
        if (dr_a && want_a) begin
            for (int k = 0; k < 4; k++) if (beats_a * 4 + k < 5) copy_a[beats_a * 4 + k] = data_a[k*16 +: 16];
            if (q_a.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL a_unexpected_beat: got %h, required no beat", data_a);
            end else chk("a_beat", data_a, q_a.pop_front());
            beats_a++;
        end
    end

    always @(negedge clk) begin
        if (busy_c && !busy_d_c) begin
            re_cnt_c = 0;
            beats_c = 0;
            rexp_c = 0;
        end
        busy_d_c = busy_c;
        if (re_c) begin
            chk("c_raddr", 64'(raddr_c), 64'(rexp_c));
            rexp_c++;
            re_cnt_c++;
        end
        if (dr_c && want_c) begin
            if (q_c.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL c_unexpected_beat: got %h, required no beat", data_c);
            end else chk("c_beat", data_c, q_c.pop_front());
            beats_c++;
        end
    end

    function automatic logic [63:0] pack_a(input int b);
        logic [63:0] r = '0;
        for (int k = 0; k < 4; k++) if (b * 4 + k < 5) r[k*16 +: 16] = mem_a[b * 4 + k];
        return r;
    endfunction

    task automatic push_a();
        for (int b = 0; b < 2; b++) q_a.push_back(pack_a(b));
    endtask

    task automatic pulse_a();
        @(posedge clk) #1 start_a = 1;
        @(posedge clk) #1 start_a = 0;
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (!done_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("a_done_seen", done_a, 1);
    endtask

    task automatic wait_ready_a();
        int t = 0;
        while (!dr_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("a_ready_seen", dr_a, 1);
    endtask

    typedef struct {
        logic        start;
        logic        busy, re, dr, done;
        logic [1:0]  raddr;
        logic [63:0] data;
    } vec_t;
    vec_t tab [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t, d0, r0;
        logic [63:0] hold;
        logic [3:0] ha;
        logic stable;
        tab[0]  = '{1, 0, 0, 0, 0, 0, 64'h0};
        tab[1]  = '{0, 1, 1, 0, 0, 0, 64'h0};
        tab[2]  = '{0, 1, 1, 0, 0, 1, 64'h0};
        tab[3]  = '{0, 1, 0, 0, 0, 0, 64'h0};
        tab[4]  = '{0, 1, 0, 1, 0, 0, 64'h000000A1_000000A0};
        tab[5]  = '{0, 1, 1, 0, 0, 2, 64'h0};
        tab[6]  = '{0, 1, 1, 0, 0, 3, 64'h0};
        tab[7]  = '{0, 1, 0, 0, 0, 0, 64'h0};
        tab[8]  = '{0, 1, 0, 1, 0, 0, 64'h000000A3_000000A2};
        tab[9]  = '{0, 1, 0, 0, 1, 0, 64'h0};
        tab[10] = '{1, 0, 0, 0, 0, 0, 64'h0};
        tab[11] = '{0, 1, 1, 0, 0, 0, 64'h0};
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i + 1);
        for (int i = 0; i < 4; i++) mem_b[i] = 32'(8'hA0 + i);
        for (int i = 0; i < 16; i++) mem_c[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 7);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("a_reset_ctl", {busy_a, done_a, re_a, dr_a}, 4'b0);
        chk("a_reset_data", data_a, 0);
        chk("a_reset_raddr", raddr_a, 0);
        chk("b_reset_ctl", {busy_b, done_b, re_b, dr_b}, 4'b0);
        chk("b_reset_data", data_b, 0);
        chk("c_reset_ctl", {busy_c, done_c, re_c, dr_c, raddr_c}, 8'b0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk) #1 start_b = tab[i].start;
            @(negedge clk);
            chk($sformatf("b_cycle%0d_ctl", i), {busy_b, re_b, dr_b, done_b},
                {tab[i].busy, tab[i].re, tab[i].dr, tab[i].done});
            if (tab[i].re) chk($sformatf("b_cycle%0d_raddr", i), raddr_b, tab[i].raddr);
            if (tab[i].dr) chk($sformatf("b_cycle%0d_data", i), data_b, tab[i].data);
        end
        @(posedge clk) #1 start_b = 0;
        t = 0;
        while (!done_b && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("b_second_done", done_b, 1);

        push_a();
        pulse_a();
        wait_done_a();
        chk("a_re_count", re_cnt_a, 5);
        chk("a_beats", beats_a, 2);
        chk("a_queue_empty", q_a.size(), 0);

        @(posedge clk) #1 want_a = 0;
        push_a();
        pulse_a();
        wait_ready_a();
        hold = data_a;
        ha = raddr_a;
        r0 = re_cnt_a;
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (!dr_a || data_a !== hold || raddr_a !== ha) stable = 0;
        end
        chk("a_stall_stable", stable, 1);
        chk("a_stall_no_re", re_cnt_a, r0);
        chk("a_stall_first_beat", hold, 64'h0004_0003_0002_0001);
        @(posedge clk) #1 want_a = 1;
        wait_done_a();
        chk("a_stall_re_count", re_cnt_a, 5);
        chk("a_stall_beats", beats_a, 2);

        push_a();
        pulse_a();
        t = 0;
        while (!(beats_a == 1 && re_a) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("a_second_fetch_seen", re_a, 1);
        d0 = done_cnt_a;
        #2 reset = 1;
        #1;
        chk("a_async_reset_ctl", {busy_a, done_a, re_a, dr_a}, 4'b0);
        chk("a_async_reset_data", data_a, 0);
        chk("a_async_reset_raddr", raddr_a, 0);
        @(posedge clk) #1 reset = 0;
        q_a.delete();
        repeat (5) @(negedge clk);
        chk("a_no_done_after_reset", done_cnt_a, d0);
        push_a();
        pulse_a();
        wait_done_a();
        chk("a_after_reset_re", re_cnt_a, 5);
        chk("a_after_reset_beats", beats_a, 2);

        for (int i = 0; i < 16; i++) mem_a[i] = 16'hBEE0 ^ 16'(i * 16'h1111);
        for (int i = 0; i < 5; i++) copy_a[i] = 'x;
        d0 = done_cnt_a;
        push_a();
        pulse_a();
        @(posedge clk) #1 start_a = 1;
        @(posedge clk) #1 start_a = 0;
        want_a = 0;
        wait_ready_a();
        @(posedge clk) #1 start_a = 1;
        @(posedge clk) #1 start_a = 0;
        want_a = 1;
        wait_done_a();
        chk("a_busy_start_done_cnt", done_cnt_a, d0 + 1);
        chk("a_busy_start_beats", beats_a, 2);
        chk("a_busy_start_re", re_cnt_a, 5);
        stable = 1;
        repeat (4) begin
            @(negedge clk);
            if (busy_a) stable = 0;
        end
        chk("a_busy_start_no_restart", stable, 1);
        for (int i = 0; i < 5; i++) chk($sformatf("a_roundtrip%0d", i), copy_a[i], mem_a[i]);

        for (int i = 0; i < 16; i++) q_c.push_back(mem_c[i]);
        @(posedge clk) #1 start_c = 1;
        @(posedge clk) #1 start_c = 0;
        t = 0;
        while (!done_c && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("c_done_seen", done_c, 1);
        chk("c_re_count", re_cnt_c, 16);
        chk("c_beats", beats_c, 16);
        repeat (3) @(negedge clk);
        chk("c_no_17th_read", re_cnt_c, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
